div8x4_seq: RTL
===============

// Module: div8x4_seq
// PURPOSE
//  Sequential restoring divider: DIVIDEND_W-bit unsigned dividend / DIVISOR_W-bit
//  unsigned divisor -> quotient + remainder, one quotient bit per clock.
//  Inverse companion of the mult8x8 FSM datapath; used where products are undone
//  (scaling, averaging). Start/done handshake; operands latched at start.
// PARAMETERS
//  DIVIDEND_W  8  dividend and quotient width
//  DIVISOR_W   4  divisor and remainder width (DIVISOR_W <= DIVIDEND_W)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-high reset
//  start      in   1            request; sampled only in IDLE
//  dataa      in   DIVIDEND_W   dividend
//  datab      in   DIVISOR_W    divisor
//  quotient   out  DIVIDEND_W   registered quotient, holds until next done
//  remainder  out  DIVISOR_W    registered remainder, holds until next done
//  busy       out  1            high while CALC
//  done       out  1            one-cycle pulse, results valid in that cycle
//  div_by_zero out 1            only with DIV_ZERO_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (any time, incl. mid-operation): state=IDLE, quotient=0, remainder=0,
//    busy=0, done=0, div_by_zero=0, internal counter/partial regs cleared.
//  - States: IDLE, CALC.
//    IDLE --start=1 @edge k--> CALC; dataa/datab latched, partial remainder=0,
//      bit counter=DIVIDEND_W-1, busy=1 from edge k.
//    CALC: each edge, partial remainder r (DIVISOR_W+1 bits) = {r, next dividend
//      bit MSB-first}; if r >= divisor: r -= divisor, q bit=1 else q bit=0.
//    Last iteration at edge k+DIVIDEND_W: quotient/remainder registers loaded,
//      done=1, busy=0, state->IDLE.
//  - Latency: start at edge k -> done high in cycle after edge k+DIVIDEND_W
//    (k+8 default); exactly one cycle wide.
//  - Back-to-back: start during the done cycle is accepted (state already IDLE).
//  - start while busy: ignored, no effect on running op or latched operands.
//  - dataa/datab changes after edge k: no effect.
//  - Results: quotient = floor(dataa/datab), remainder = dataa mod datab,
//    remainder < datab always (datab != 0).
//  - Divisor 0 (no macro): full DIVIDEND_W-cycle run, quotient = all ones,
//    remainder = dataa[DIVISOR_W-1:0].
// CONFIGURATION
//  DIV_ZERO_FLAG_EN defined: div_by_zero port present. datab==0 at start ->
//    CALC skipped; done pulses in cycle after edge k+1, quotient=all ones,
//    remainder=0, div_by_zero=1 coincident with done and held until the next
//    done (cleared on a nonzero-divisor completion). busy high for that 1 cycle.
//  Not defined: port absent; divisor 0 handled as in BEHAVIOUR.
// TESTING
//  1. dataa=200, datab=7, start 1 cycle -> done 8 edges later, quotient=28,
//     remainder=4, busy high exactly 8 cycles.
//  2. 255/15 -> 17 r 0; 5/9 -> 0 r 5; 15/1 -> 15 r 0; results held after done.
//  3. Back-to-back: start during done with 100/3 -> 33 r 1, done 8 edges later.
//  4. Start pulsed + operands changed mid-CALC (200/7 running, 9/3 applied)
//     -> result still 28 r 4, single done pulse.
//  5. reset at 4th CALC cycle -> all outputs 0, no done; next 81/9 -> 9 r 0.
//  6. Divisor 0, 0xA6/0: no macro -> 8 cycles, quotient=0xFF, remainder=6;
//     DIV_ZERO_FLAG_EN -> done after 1 cycle, 0xFF r 0, div_by_zero=1, then
//     12/4 -> 3 r 0 with div_by_zero=0.
//  Bench also sweeps all 256x15 nonzero-divisor pairs against / and % model.

Source files
------------

// File: rtl/div8x4_seq_if.sv
// rtl/div8x4_seq_if.sv - start/done request and result bundle for the sequential divider (optional DIV_ZERO_FLAG_EN)
interface div8x4_seq_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dataa;
    logic [DIVISOR_W-1:0]  datab;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  busy;
    logic                  done;
`ifdef DIV_ZERO_FLAG_EN
    logic                  div_by_zero;
`endif

`ifdef DIV_ZERO_FLAG_EN
    modport master (output start, dataa, datab,
                    input  quotient, remainder, busy, done, div_by_zero);
    modport slave  (input  start, dataa, datab,
                    output quotient, remainder, busy, done, div_by_zero);
`else
    modport master (output start, dataa, datab,
                    input  quotient, remainder, busy, done);
    modport slave  (input  start, dataa, datab,
                    output quotient, remainder, busy, done);
`endif
endinterface

// File: rtl/div8x4_seq.sv
// rtl/div8x4_seq.sv - restoring divider, one quotient bit per clock; DIV_ZERO_FLAG_EN adds early div-by-zero exit
module div8x4_seq #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    div8x4_seq_if.slave bus
);
    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t                r_state, w_state_nx;
    logic [DIVIDEND_W-1:0] r_dvd,  w_dvd_nx;    // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [DIVISOR_W-1:0]  r_dsr,  w_dsr_nx;
    logic [DIVISOR_W-1:0]  r_part, w_part_nx;   // partial remainder, always < divisor after restore
    logic [CW-1:0]         r_cnt,  w_cnt_nx;
    logic [DIVIDEND_W-1:0] r_quot, w_quot_nx;
    logic [DIVISOR_W-1:0]  r_rem,  w_rem_nx;
    logic                  r_done, w_done_nx;
`ifdef DIV_ZERO_FLAG_EN
    logic                  r_zero, w_zero_nx;   // latched divisor==0 for the running op
    logic                  r_dz,   w_dz_nx;     // visible flag, updated only on completion
`endif

    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_part_step;
    logic [DIVIDEND_W-1:0] w_dvd_step;

    // One restoring step: bring in next dividend bit, subtract divisor if it fits.
    // A zero divisor always "fits", giving all-ones quotient and the low dividend bits as remainder.
    always_comb begin
        w_shift     = {r_part, r_dvd[DIVIDEND_W-1]};
        w_ge        = (w_shift >= {1'b0, r_dsr});
        w_diff      = w_shift - {1'b0, r_dsr};
        w_part_step = w_ge ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
        w_dvd_step  = {r_dvd[DIVIDEND_W-2:0], w_ge};
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nx = r_state;
        w_dvd_nx   = r_dvd;
        w_dsr_nx   = r_dsr;
        w_part_nx  = r_part;
        w_cnt_nx   = r_cnt;
        w_quot_nx  = r_quot;
        w_rem_nx   = r_rem;
        w_done_nx  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        w_zero_nx  = r_zero;
        w_dz_nx    = r_dz;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_CALC;
                    w_dvd_nx   = bus.dataa;
                    w_dsr_nx   = bus.datab;
                    w_part_nx  = '0;
                    w_cnt_nx   = CW'(DIVIDEND_W - 1);
`ifdef DIV_ZERO_FLAG_EN
                    w_zero_nx  = (bus.datab == '0);
`endif
                end
            end
            S_CALC: begin
`ifdef DIV_ZERO_FLAG_EN
                if (r_zero) begin
                    w_state_nx = S_IDLE;
                    w_quot_nx  = '1;
                    w_rem_nx   = '0;
                    w_done_nx  = 1'b1;
                    w_dz_nx    = 1'b1;
                    w_zero_nx  = 1'b0;
                end else
`endif
                begin
                    w_dvd_nx  = w_dvd_step;
                    w_part_nx = w_part_step;
                    w_cnt_nx  = r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        w_state_nx = S_IDLE;
                        w_quot_nx  = w_dvd_step;
                        w_rem_nx   = w_part_step;
                        w_done_nx  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        w_dz_nx    = 1'b0;
`endif
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, including a run in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_part  <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            r_zero  <= 1'b0;
            r_dz    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_dvd   <= w_dvd_nx;
            r_dsr   <= w_dsr_nx;
            r_part  <= w_part_nx;
            r_cnt   <= w_cnt_nx;
            r_quot  <= w_quot_nx;
            r_rem   <= w_rem_nx;
            r_done  <= w_done_nx;
`ifdef DIV_ZERO_FLAG_EN
            r_zero  <= w_zero_nx;
            r_dz    <= w_dz_nx;
`endif
        end
    end

    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.busy      = (r_state == S_CALC);
    assign bus.done      = r_done;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_by_zero = r_dz;
`endif
endmodule
